// File: rtl/instrumented_ring_counter.sv
// instrumented_ring_counter: counts synchronised rising edges of a ring oscillator over a
// programmable window of wb_clk_i cycles and holds the result for readback.
module instrumented_ring_counter #(
   parameter int CNT_W       = 32,
   parameter int GATE_W      = 24,
   parameter int SYNC_STAGES = 2
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_n,
   input  logic              active,
   input  logic              start,
   input  logic              abort,
   input  logic [GATE_W-1:0] gate_cycles,
   input  logic              ring_in,
   output logic [CNT_W-1:0]  count,
   output logic              overflow,
   output logic              busy,
   output logic              done
);
   localparam int AW = $clog2(SYNC_STAGES + 1);
   localparam logic [AW-1:0] ARM_LAST = AW'(SYNC_STAGES);
   typedef enum logic [1:0] {IDLE, ARM, COUNT, DONE} state_t;
   state_t state;
   logic [SYNC_STAGES-1:0] sync;
   logic prev;
   logic [GATE_W-1:0] gate_cnt;
   logic [AW-1:0] arm_cnt;
   logic rise;
   assign rise = sync[SYNC_STAGES-1] & ~prev;
   always_ff @(posedge wb_clk_i or negedge wb_rst_n)
      if (!wb_rst_n) begin
         state    <= IDLE;
         sync     <= '0;
         prev     <= 1'b0;
         gate_cnt <= '0;
         arm_cnt  <= '0;
         count    <= '0;
         overflow <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], ring_in};
         prev <= sync[SYNC_STAGES-1];
         if (!active) begin
            state    <= IDLE;
            count    <= '0;
            overflow <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
         end else if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
         end else
            case (state)
               IDLE, DONE:
                  if (start) begin
                     state    <= ARM;
                     busy     <= 1'b1;
                     done     <= 1'b0;
                     gate_cnt <= gate_cycles;
                     arm_cnt  <= '0;
                     count    <= '0;
                     overflow <= 1'b0;
                  end
               // hold off counting until the synchroniser holds only post-start samples
               ARM:
                  if (arm_cnt == ARM_LAST) begin
                     if (gate_cnt == '0) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                     end else
                        state <= COUNT;
                  end else
                     arm_cnt <= arm_cnt + 1'b1;
               COUNT: begin
                  gate_cnt <= gate_cnt - 1'b1;
                  if (rise) begin
                     if (&count) overflow <= 1'b1;
                     else count <= count + 1'b1;
                  end
                  if (gate_cnt == GATE_W'(1)) begin
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end
               end
               default: state <= IDLE;
            endcase
      end
endmodule

// File: tb/tb_instrumented_ring_counter.sv
// tb_instrumented_ring_counter: randomized bench against a window-of-samples reference model.
module tb_instrumented_ring_counter;
   localparam int S = 2;
   logic wb_clk_i = 1'b0;
   always #5 wb_clk_i = ~wb_clk_i;
   logic wb_rst_n = 1'b0, active = 1'b1, start = 1'b0, abort = 1'b0, ring_in = 1'b0;
   logic [23:0] gate_cycles = '0;
   logic [31:0] count;
   logic [3:0] count4;
   logic overflow, busy, done, ov4, busy4, done4;
   int checks = 0, errors = 0, mode = 2, ph = 0, edge_n = 0, e0;
   bit hist [0:65535];

   instrumented_ring_counter #(.CNT_W(32), .GATE_W(24), .SYNC_STAGES(S)) dut (
      .wb_clk_i(wb_clk_i), .wb_rst_n(wb_rst_n), .active(active), .start(start), .abort(abort),
      .gate_cycles(gate_cycles), .ring_in(ring_in), .count(count), .overflow(overflow),
      .busy(busy), .done(done));
   instrumented_ring_counter #(.CNT_W(4), .GATE_W(24), .SYNC_STAGES(S)) dut4 (
      .wb_clk_i(wb_clk_i), .wb_rst_n(wb_rst_n), .active(active), .start(start), .abort(abort),
      .gate_cycles(gate_cycles), .ring_in(ring_in), .count(count4), .overflow(ov4),
      .busy(busy4), .done(done4));

   // ring_in as sampled at every clock edge, indexed by edge number
   always @(posedge wb_clk_i) begin
      hist[edge_n] <= ring_in;
      edge_n <= edge_n + 1;
   end

   always @(negedge wb_clk_i) begin
      case (mode)
         0: ring_in = 1'($urandom % 2);
         1: if (ph % 5 == 0) ring_in = ~ring_in;
         3: if (ph % 2 == 0) ring_in = ~ring_in;
         default: ring_in = 1'b1;
      endcase
      ph++;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // rises seen by a window of g cycles: 0->1 steps between samples e0+1 .. e0+g+1
   function automatic int exp_rises(input int e, input int g);
      int n = 0;
      for (int j = 2; j <= g + 1; j++) n += (hist[e + j] && !hist[e + j - 1]) ? 1 : 0;
      return n;
   endfunction

   task automatic launch(input int g, output int e);
      @(negedge wb_clk_i);
      gate_cycles = 24'(g);
      start = 1'b1;
      e = edge_n;
      @(negedge wb_clk_i);
      start = 1'b0;
      gate_cycles = 24'($urandom);
   endtask

   task automatic measure(input int g, input string tag);
      int lat = 0, r;
      launch(g, e0);
      chk({tag, "_busy_up"}, busy, 1);
      chk({tag, "_done_lo"}, done, 0);
      while (!done && lat < g + S + 20) begin
         @(negedge wb_clk_i);
         lat++;
      end
      r = exp_rises(e0, g);
      chk({tag, "_latency"}, lat, S + 1 + g);
      chk({tag, "_done"}, done, 1);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_count"}, count, r);
      chk({tag, "_ovf"}, overflow, 0);
      chk({tag, "_count4"}, count4, r > 15 ? 15 : r);
      chk({tag, "_ovf4"}, ov4, r > 15 ? 1 : 0);
      chk({tag, "_done4"}, done4, 1);
   endtask

   task automatic all_zero(input string tag);
      chk({tag, "_count"}, count, 0);
      chk({tag, "_ovf"}, overflow, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
   endtask

   initial begin
      int g;
      repeat (3) @(negedge wb_clk_i);
      all_zero("reset");
      wb_rst_n = 1'b1;
      mode = 1;
      repeat (4) @(negedge wb_clk_i);
      measure(1000, "s1");
      chk("s1_exact100", count, 100);
      mode = 2;
      repeat (10) @(negedge wb_clk_i);
      measure(50, "s2");
      chk("s2_zero", count, 0);
      mode = 3;
      measure(100, "s3");
      chk("s3_sat4", count4, 15);
      chk("s3_ovf4", ov4, 1);
      measure(0, "s4");
      chk("s4_zero", count, 0);
      mode = 1;
      launch(1000, e0);
      repeat (S + 1 + 20) @(negedge wb_clk_i);
      start = 1'b1;
      @(negedge wb_clk_i);
      start = 1'b0;
      repeat (300 - 21) @(negedge wb_clk_i);
      chk("s5_busy_pre", busy, 1);
      abort = 1'b1;
      @(negedge wb_clk_i);
      abort = 1'b0;
      chk("s5_busy", busy, 0);
      chk("s5_done", done, 0);
      chk("s5_partial", count, exp_rises(e0, 300));
      repeat (5) @(negedge wb_clk_i);
      chk("s5_held", count, exp_rises(e0, 300));
      chk("s5_idle_busy", busy, 0);
      launch(1000, e0);
      repeat (200) @(negedge wb_clk_i);
      wb_rst_n = 1'b0;
      #1;
      all_zero("s6_rst");
      @(negedge wb_clk_i);
      wb_rst_n = 1'b1;
      measure(1000, "s6_rst_re");
      chk("s6_rst_100", count, 100);
      launch(1000, e0);
      repeat (200) @(negedge wb_clk_i);
      active = 1'b0;
      @(negedge wb_clk_i);
      all_zero("s6_act");
      start = 1'b1;
      @(negedge wb_clk_i);
      start = 1'b0;
      @(negedge wb_clk_i);
      chk("s6_act_start_ign", busy, 0);
      active = 1'b1;
      measure(1000, "s6_act_re");
      chk("s6_act_100", count, 100);
      mode = 0;
      for (int i = 0; i < 6; i++) begin
         g = $urandom_range(0, 300);
         measure(g, $sformatf("rnd%0d", i));
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
